// File: rtl/wb_master_arbiter_pkg.sv
// Shared definitions for the instruction/data Wishbone master arbiter.
// The state encoding doubles as the one-hot {d,i} grant vector.
package wb_master_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'b00,
    ARB_GNT_I = 2'b01,
    ARB_GNT_D = 2'b10
  } arb_state_e;

  // Default D-grants allowed while I waits, and default ack timeout in cycles.
  localparam int unsigned ARB_STARVE_MAX = 32'd4;
  localparam int unsigned ARB_TIMEOUT    = 32'd255;

  // Grant vector {d,i} seen by the outside world for a given arbiter state.
  function automatic logic [1:0] arb_gnt(input arb_state_e st);
    case (st)
      ARB_GNT_I: arb_gnt = 2'b01;
      ARB_GNT_D: arb_gnt = 2'b10;
      default:   arb_gnt = 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/wb_arb_watchdog.sv
// Bus watchdog: counts strobe cycles that go unacknowledged and fires a
// one-cycle expire pulse on the TIMEOUT-th such cycle. Keeps a sticky flag.
module wb_arb_watchdog
  import wb_master_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = ARB_TIMEOUT
) (
  input  logic clk,
  input  logic rst,        // asynchronous, active-low
  input  logic active_i,   // a master currently owns the bus
  input  logic stb_i,      // owner's raw strobe (before any forcing)
  input  logic ack_i,      // slave acknowledge
  output logic expire_o,   // combinational: this cycle is the timeout cycle
  output logic timeout_o   // sticky: a timeout has happened since reset
);

  // The counter only ever needs to hold 0 .. TIMEOUT-1.
  localparam int unsigned CW = (TIMEOUT > 32'd1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 32'd1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          timeout_q, timeout_d;

  // Expire when the waiting strobe would make the count reach TIMEOUT;
  // an ack in that same cycle wins, so ack and err never coincide.
  always_comb begin
    expire_o = 1'b0;
    if (active_i && stb_i && !ack_i && (cnt_q == LAST)) begin
      expire_o = 1'b1;
    end else begin
      expire_o = 1'b0;
    end
  end

  // Next count and sticky flag: clear while idle, on ack or on expiry.
  always_comb begin
    cnt_d     = cnt_q;
    timeout_d = timeout_q | expire_o;
    if (!active_i || ack_i || expire_o) begin
      cnt_d = {CW{1'b0}};
    end else if (stb_i) begin
      cnt_d = cnt_q + CW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter and sticky flag registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q     <= {CW{1'b0}};
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_o = timeout_q;

endmodule

// File: rtl/wb_master_arbiter.sv
// Shares one Wishbone master port between the CPU instruction-side and
// data-side masters. Fixed priority D > I with an anti-starvation count for
// I, grant locked for a whole cyc, and a watchdog that ends hung transfers
// with err. Bus outputs are muxed combinationally from the registered state.
module wb_master_arbiter
  import wb_master_arbiter_pkg::*;
#(
  parameter int unsigned AW         = 32,
  parameter int unsigned DW         = 32,
  parameter int unsigned STARVE_MAX = ARB_STARVE_MAX,
  parameter int unsigned TIMEOUT    = ARB_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,        // asynchronous, active-low
  // instruction-side master
  input  logic              i_cyc_i,
  input  logic              i_stb_i,
  input  logic              i_we_i,
  input  logic [DW/8-1:0]   i_sel_i,
  input  logic [AW-1:0]     i_addr_i,
  input  logic [DW-1:0]     i_data_i,
  output logic [DW-1:0]     i_data_o,
  output logic              i_ack_o,
  output logic              i_err_o,
  // data-side master
  input  logic              d_cyc_i,
  input  logic              d_stb_i,
  input  logic              d_we_i,
  input  logic [DW/8-1:0]   d_sel_i,
  input  logic [AW-1:0]     d_addr_i,
  input  logic [DW-1:0]     d_data_i,
  output logic [DW-1:0]     d_data_o,
  output logic              d_ack_o,
  output logic              d_err_o,
  // shared slave-side port
  input  logic [DW-1:0]     wb_data_i,
  input  logic              wb_ack_i,
  output logic              wb_cyc_o,
  output logic              wb_stb_o,
  output logic              wb_we_o,
  output logic [DW/8-1:0]   wb_sel_o,
  output logic [AW-1:0]     wb_addr_o,
  output logic [DW-1:0]     wb_data_o,
  // status
  output logic [1:0]        gnt_o,
  output logic              timeout_o
);

  localparam int unsigned SELW = DW / 8;
  localparam int unsigned SW   = (STARVE_MAX > 32'd0) ? $clog2(STARVE_MAX + 32'd1) : 1;
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  arb_state_e    state_q, state_d;
  logic [SW-1:0] starve_q, starve_d;

  logic own_active;
  logic own_stb;
  logic wd_expire;

  // Raw strobe of whichever master owns the bus; feeds the watchdog.
  always_comb begin
    own_active = 1'b0;
    own_stb    = 1'b0;
    case (state_q)
      ARB_GNT_I: begin
        own_active = 1'b1;
        own_stb    = i_stb_i;
      end
      ARB_GNT_D: begin
        own_active = 1'b1;
        own_stb    = d_stb_i;
      end
      default: begin
        own_active = 1'b0;
        own_stb    = 1'b0;
      end
    endcase
  end

  wb_arb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk       (clk),
    .rst       (rst),
    .active_i  (own_active),
    .stb_i     (own_stb),
    .ack_i     (wb_ack_i),
    .expire_o  (wd_expire),
    .timeout_o (timeout_o)
  );

  // Arbitration and release: pick an owner from IDLE, hold it for the whole
  // cyc, and always pass through IDLE between owners.
  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    case (state_q)
      ARB_IDLE: begin
        if (d_cyc_i && (starve_q < STARVE_LIM)) begin
          state_d = ARB_GNT_D;
          // Guarded by the compare above, so the increment cannot overflow.
          if (i_cyc_i) begin
            starve_d = starve_q + SW'(1);
          end else begin
            starve_d = {SW{1'b0}};
          end
        end else if (i_cyc_i) begin
          state_d  = ARB_GNT_I;
          starve_d = {SW{1'b0}};
        end else if (d_cyc_i) begin
          state_d  = ARB_GNT_D;
          starve_d = {SW{1'b0}};
        end else begin
          state_d  = ARB_IDLE;
          starve_d = {SW{1'b0}};
        end
      end
      ARB_GNT_I: begin
        if (wd_expire || !i_cyc_i) begin
          state_d = ARB_IDLE;
        end else begin
          state_d = ARB_GNT_I;
        end
      end
      ARB_GNT_D: begin
        if (wd_expire || !d_cyc_i) begin
          state_d = ARB_IDLE;
        end else begin
          state_d = ARB_GNT_D;
        end
      end
      default: begin
        state_d  = ARB_IDLE;
        starve_d = {SW{1'b0}};
      end
    endcase
  end

  // State and starvation counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ARB_IDLE;
      starve_q <= {SW{1'b0}};
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

  // Bus and master-return muxes; on the timeout cycle the bus is dropped and
  // the owner gets err instead of ack.
  always_comb begin
    wb_cyc_o  = 1'b0;
    wb_stb_o  = 1'b0;
    wb_we_o   = 1'b0;
    wb_sel_o  = {SELW{1'b0}};
    wb_addr_o = {AW{1'b0}};
    wb_data_o = {DW{1'b0}};
    i_data_o  = {DW{1'b0}};
    i_ack_o   = 1'b0;
    i_err_o   = 1'b0;
    d_data_o  = {DW{1'b0}};
    d_ack_o   = 1'b0;
    d_err_o   = 1'b0;
    gnt_o     = arb_gnt(state_q);
    case (state_q)
      ARB_GNT_I: begin
        wb_cyc_o  = i_cyc_i & ~wd_expire;
        wb_stb_o  = i_stb_i & ~wd_expire;
        wb_we_o   = i_we_i;
        wb_sel_o  = i_sel_i;
        wb_addr_o = i_addr_i;
        wb_data_o = i_data_i;
        i_data_o  = wb_data_i;
        i_ack_o   = wb_ack_i & ~wd_expire;
        i_err_o   = wd_expire;
      end
      ARB_GNT_D: begin
        wb_cyc_o  = d_cyc_i & ~wd_expire;
        wb_stb_o  = d_stb_i & ~wd_expire;
        wb_we_o   = d_we_i;
        wb_sel_o  = d_sel_i;
        wb_addr_o = d_addr_i;
        wb_data_o = d_data_i;
        d_data_o  = wb_data_i;
        d_ack_o   = wb_ack_i & ~wd_expire;
        d_err_o   = wd_expire;
      end
      default: begin
        wb_cyc_o = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_wb_master_arbiter.sv
// Self-checking bench for wb_master_arbiter: directed scenarios followed by
// random traffic, every cycle compared against a behavioural owner model.
module tb_wb_master_arbiter;

  localparam int AW         = 32;
  localparam int DW         = 32;
  localparam int STARVE_MAX = 4;
  localparam int TIMEOUT    = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic          i_cyc_i, i_stb_i, i_we_i;
  logic [3:0]    i_sel_i;
  logic [31:0]   i_addr_i, i_data_i, i_data_o;
  logic          i_ack_o, i_err_o;
  logic          d_cyc_i, d_stb_i, d_we_i;
  logic [3:0]    d_sel_i;
  logic [31:0]   d_addr_i, d_data_i, d_data_o;
  logic          d_ack_o, d_err_o;
  logic [31:0]   wb_data_i;
  logic          wb_ack_i;
  logic          wb_cyc_o, wb_stb_o, wb_we_o;
  logic [3:0]    wb_sel_o;
  logic [31:0]   wb_addr_o, wb_data_o;
  logic [1:0]    gnt_o;
  logic          timeout_o;

  int checks = 0;
  int errors = 0;

  // Reference model: who owns the bus (0 none, 1 I, 2 D), starvation count,
  // unacked-strobe count of the current owner, sticky timeout.
  int m_own, m_starve, m_wd;
  bit m_tout;

  wb_master_arbiter #(
    .AW(AW), .DW(DW), .STARVE_MAX(STARVE_MAX), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .i_cyc_i(i_cyc_i), .i_stb_i(i_stb_i), .i_we_i(i_we_i), .i_sel_i(i_sel_i),
    .i_addr_i(i_addr_i), .i_data_i(i_data_i), .i_data_o(i_data_o),
    .i_ack_o(i_ack_o), .i_err_o(i_err_o),
    .d_cyc_i(d_cyc_i), .d_stb_i(d_stb_i), .d_we_i(d_we_i), .d_sel_i(d_sel_i),
    .d_addr_i(d_addr_i), .d_data_i(d_data_i), .d_data_o(d_data_o),
    .d_ack_o(d_ack_o), .d_err_o(d_err_o),
    .wb_data_i(wb_data_i), .wb_ack_i(wb_ack_i),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_sel_o(wb_sel_o), .wb_addr_o(wb_addr_o), .wb_data_o(wb_data_o),
    .gnt_o(gnt_o), .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_own = 0; m_starve = 0; m_wd = 0; m_tout = 1'b0;
  endtask

  // Owner's raw request lines as the model sees them.
  function automatic bit own_cyc();
    return (m_own == 1) ? i_cyc_i : (m_own == 2) ? d_cyc_i : 1'b0;
  endfunction
  function automatic bit own_stb();
    return (m_own == 1) ? i_stb_i : (m_own == 2) ? d_stb_i : 1'b0;
  endfunction
  function automatic bit fire_now();
    return (m_own != 0) && own_stb() && !wb_ack_i && (m_wd == TIMEOUT - 1);
  endfunction

  // Compare every DUT output with what the model says this cycle should show.
  task automatic model_check();
    logic        e_cyc, e_stb, e_we, f;
    logic [3:0]  e_sel;
    logic [31:0] e_addr, e_wdat, e_idat, e_ddat;
    logic        e_iack, e_ierr, e_dack, e_derr;
    logic [1:0]  e_gnt;
    e_cyc = 0; e_stb = 0; e_we = 0; e_sel = 4'h0; e_addr = 32'h0; e_wdat = 32'h0;
    e_idat = 32'h0; e_iack = 0; e_ierr = 0; e_ddat = 32'h0; e_dack = 0; e_derr = 0;
    f = fire_now();
    e_gnt = (m_own == 2) ? 2'b10 : (m_own == 1) ? 2'b01 : 2'b00;
    if (m_own == 1) begin
      e_cyc = i_cyc_i && !f; e_stb = i_stb_i && !f; e_we = i_we_i; e_sel = i_sel_i;
      e_addr = i_addr_i; e_wdat = i_data_i;
      e_idat = wb_data_i; e_iack = wb_ack_i; e_ierr = f;
    end else if (m_own == 2) begin
      e_cyc = d_cyc_i && !f; e_stb = d_stb_i && !f; e_we = d_we_i; e_sel = d_sel_i;
      e_addr = d_addr_i; e_wdat = d_data_i;
      e_ddat = wb_data_i; e_dack = wb_ack_i; e_derr = f;
    end
    chk("gnt", gnt_o, e_gnt);
    chk("bus", {wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_addr_o, wb_data_o},
               {e_cyc, e_stb, e_we, e_sel, e_addr, e_wdat});
    chk("i_ret", {i_data_o, i_ack_o, i_err_o}, {e_idat, e_iack, e_ierr});
    chk("d_ret", {d_data_o, d_ack_o, d_err_o}, {e_ddat, e_dack, e_derr});
    chk("timeout", timeout_o, m_tout);
  endtask

  // Advance the model across one rising edge using the current inputs.
  task automatic model_next();
    bit f;
    f = fire_now();
    if (!rst) begin
      model_reset();
    end else if (m_own == 0) begin
      if (d_cyc_i && m_starve < STARVE_MAX) begin
        m_own = 2;
        m_starve = i_cyc_i ? ((m_starve + 1 > STARVE_MAX) ? STARVE_MAX : m_starve + 1) : 0;
      end else if (i_cyc_i) begin
        m_own = 1; m_starve = 0;
      end else if (d_cyc_i) begin
        m_own = 2; m_starve = 0;
      end else begin
        m_starve = 0;
      end
      m_wd = 0;
    end else if (f) begin
      m_tout = 1'b1; m_own = 0; m_wd = 0;
    end else begin
      if (wb_ack_i) m_wd = 0;
      else if (own_stb()) m_wd = m_wd + 1;
      if (!own_cyc()) m_own = 0;
    end
  endtask

  // One clock: check at the falling edge, then step past the rising edge.
  task automatic tick();
    @(negedge clk);
    model_check();
    model_next();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] exp_seq [6];
    logic [1:0] g;
    int ack_rate;

    exp_seq[0] = 2'b10; exp_seq[1] = 2'b10; exp_seq[2] = 2'b10;
    exp_seq[3] = 2'b10; exp_seq[4] = 2'b01; exp_seq[5] = 2'b10;

    i_cyc_i = 0; i_stb_i = 0; i_we_i = 0; i_sel_i = 4'h0; i_addr_i = 32'h0; i_data_i = 32'h0;
    d_cyc_i = 0; d_stb_i = 0; d_we_i = 0; d_sel_i = 4'h0; d_addr_i = 32'h0; d_data_i = 32'h0;
    wb_data_i = 32'h0; wb_ack_i = 0;
    model_reset();

    // Reset state
    tick();
    chk("rst_gnt", gnt_o, 2'b00);
    chk("rst_cyc", wb_cyc_o, 1'b0);
    tick();
    rst = 1'b1;
    tick();

    // Simultaneous requests: D wins, ack two cycles later, I after the dead cycle
    i_cyc_i = 1; i_stb_i = 1; i_sel_i = 4'hF; i_addr_i = 32'h0000_1000;
    d_cyc_i = 1; d_stb_i = 1; d_sel_i = 4'hF; d_addr_i = 32'h0000_2000; d_data_i = 32'h1111_2222;
    tick();                                   // cycle 0
    #3; chk("t2_gnt_c1", gnt_o, 2'b10); chk("t2_addr_c1", wb_addr_o, 32'h0000_2000);
    tick();                                   // cycle 1
    tick();                                   // cycle 2
    wb_ack_i = 1; wb_data_i = 32'h0BAD_F00D;
    #3; chk("t2_dack_c3", d_ack_o, 1'b1); chk("t2_iack_c3", i_ack_o, 1'b0);
    chk("t2_ddata_c3", d_data_o, 32'h0BAD_F00D);
    tick();                                   // cycle 3
    wb_ack_i = 0; d_cyc_i = 0; d_stb_i = 0;
    #3; chk("t2_gnt_c4", gnt_o, 2'b10); chk("t2_cyc_c4", wb_cyc_o, 1'b0);
    tick();                                   // cycle 4: D released
    #3; chk("t2_gnt_c5", gnt_o, 2'b00);
    tick();                                   // cycle 5: dead cycle
    // Single I read with immediate ack
    wb_data_i = 32'h2400_0001; wb_ack_i = 1;
    #3; chk("t5_gnt", gnt_o, 2'b01); chk("t5_idata", i_data_o, 32'h2400_0001);
    chk("t5_iack", i_ack_o, 1'b1); chk("t5_dack", d_ack_o, 1'b0);
    chk("t5_iaddr", wb_addr_o, 32'h0000_1000);
    tick();                                   // cycle 6
    wb_ack_i = 0; i_cyc_i = 0; i_stb_i = 0;
    tick();
    tick();

    // D write one cycle after request
    d_cyc_i = 1; d_stb_i = 1; d_we_i = 1; d_sel_i = 4'b0011;
    d_addr_i = 32'h8000_0010; d_data_i = 32'hCAFE_0001;
    tick();
    #3; chk("t6_we", wb_we_o, 1'b1); chk("t6_sel", wb_sel_o, 4'b0011);
    chk("t6_addr", wb_addr_o, 32'h8000_0010); chk("t6_wdata", wb_data_o, 32'hCAFE_0001);
    wb_ack_i = 1;
    #1; chk("t6_dack", d_ack_o, 1'b1);
    tick();
    wb_ack_i = 0; d_cyc_i = 0; d_stb_i = 0; d_we_i = 0;
    tick();
    tick();

    // Starvation: I waits while D keeps requesting
    i_cyc_i = 1; i_stb_i = 1; d_cyc_i = 1; d_stb_i = 1;
    for (int t = 0; t < 6; t++) begin
      int waited;
      waited = 0;
      #3;
      while (gnt_o == 2'b00 && waited < 10) begin
        tick(); waited++; #3;
      end
      g = gnt_o;
      chk($sformatf("t3_owner_%0d", t), g, exp_seq[t]);
      wb_ack_i = 1;
      tick();
      wb_ack_i = 0;
      if (g == 2'b01) begin
        i_cyc_i = 0; i_stb_i = 0; tick(); i_cyc_i = 1; i_stb_i = 1;
      end else begin
        d_cyc_i = 0; d_stb_i = 0; tick(); d_cyc_i = 1; d_stb_i = 1;
      end
    end
    i_cyc_i = 0; i_stb_i = 0; d_cyc_i = 0; d_stb_i = 0;
    tick();
    tick();

    // Watchdog: slave never acks
    i_cyc_i = 1; i_stb_i = 1; i_addr_i = 32'h0000_0004;
    tick();                                   // cycle 0: request
    for (int c = 1; c <= 8; c++) begin
      #3;
      if (c < 8) begin
        chk($sformatf("t4_err_c%0d", c), i_err_o, 1'b0);
        chk($sformatf("t4_cyc_c%0d", c), wb_cyc_o, 1'b1);
      end else begin
        chk("t4_err_c8", i_err_o, 1'b1);
        chk("t4_cyc_c8", wb_cyc_o, 1'b0);
        chk("t4_stb_c8", wb_stb_o, 1'b0);
        chk("t4_ack_c8", i_ack_o, 1'b0);
      end
      tick();
    end
    #3; chk("t4_gnt_c9", gnt_o, 2'b00); chk("t4_tout_c9", timeout_o, 1'b1);
    tick();
    wb_ack_i = 1;
    #3; chk("t4_regnt", gnt_o, 2'b01); chk("t4_iack", i_ack_o, 1'b1);
    chk("t4_ierr", i_err_o, 1'b0);
    tick();
    wb_ack_i = 0; i_cyc_i = 0; i_stb_i = 0;
    tick();
    #3; chk("t4_tout_sticky", timeout_o, 1'b1);
    tick();

    // Asynchronous reset in the middle of a D strobe
    d_cyc_i = 1; d_stb_i = 1; d_addr_i = 32'h0000_0040;
    tick();
    #2; chk("t1_stb_before", wb_stb_o, 1'b1);
    rst = 1'b0; model_reset();
    #1; chk("t1_cyc", wb_cyc_o, 1'b0); chk("t1_gnt", gnt_o, 2'b00);
    chk("t1_tout", timeout_o, 1'b0);
    tick();
    d_cyc_i = 0; d_stb_i = 0;
    tick();
    rst = 1'b1;
    tick();

    // Random traffic against the model
    ack_rate = 2;
    for (int n = 0; n < 3000; n++) begin
      if (n % 100 == 0) ack_rate = $urandom_range(0, 3);
      if (i_cyc_i) begin
        if ($urandom_range(0, 5) == 0) i_cyc_i = 0;
      end else begin
        if ($urandom_range(0, 2) == 0) i_cyc_i = 1;
      end
      if (d_cyc_i) begin
        if ($urandom_range(0, 5) == 0) d_cyc_i = 0;
      end else begin
        if ($urandom_range(0, 2) == 0) d_cyc_i = 1;
      end
      i_stb_i = i_cyc_i && ($urandom_range(0, 3) != 0);
      d_stb_i = d_cyc_i && ($urandom_range(0, 3) != 0);
      i_we_i = 1'($urandom()); i_sel_i = 4'($urandom());
      i_addr_i = $urandom(); i_data_i = $urandom();
      d_we_i = 1'($urandom()); d_sel_i = 4'($urandom());
      d_addr_i = $urandom(); d_data_i = $urandom();
      wb_data_i = $urandom();
      wb_ack_i = ($urandom_range(0, 3) < ack_rate);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
